// File: rtl/pes_elc_scan.sv
`default_nettype none
// ============================================================================
//  Module   : pes_elc_scan
//  Purpose  : N-floor elevator car controller. Latches hall/car calls into a
//             pending bitmask and serves them in SCAN order, with modelled
//             floor-to-floor travel time, door dwell time and door/weight
//             alerts that hold the door open.
//  Revision : 1.0 - initial release
// ============================================================================
module pes_elc_scan #(
   parameter int NUM_FLOORS  = 8,
   parameter int FLOOR_W     = 3,
   parameter int MOVE_CYCLES = 4,
   parameter int DOOR_CYCLES = 6,
   parameter int RESET_FLOOR = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  call_valid,
   input  logic [FLOOR_W-1:0]    call_floor,
   input  logic                  over_time,
   input  logic                  over_weight,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic                  direction,
   output logic                  moving,
   output logic                  door_open,
   output logic                  complete,
   output logic                  door_alert,
   output logic                  weight_alert,
   output logic [NUM_FLOORS-1:0] pending
);

   // Counter widths never drop below one bit, even for single-cycle timings.
   localparam int c_MC_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
   localparam int c_DC_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [c_MC_W-1:0]  c_MOVE_LAST   = c_MC_W'(MOVE_CYCLES - 1);
   localparam logic [c_DC_W-1:0]  c_DOOR_LAST   = c_DC_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W:0]   c_FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);
   localparam logic [FLOOR_W-1:0] c_RESET_FLOOR = FLOOR_W'(RESET_FLOOR);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_MOVE_UP   = 2'd1,
      S_MOVE_DN   = 2'd2,
      S_DOOR_OPEN = 2'd3
   } state_t;

   state_t                  r_state;
   logic [FLOOR_W-1:0]      r_floor;
   logic                    r_dir;
   logic [NUM_FLOORS-1:0]   r_pending;
   logic [c_MC_W-1:0]       r_move_cnt;
   logic [c_DC_W-1:0]       r_door_cnt;
   logic                    r_door_alert;
   logic                    r_weight_alert;

   logic                    w_step;
   logic [FLOOR_W-1:0]      w_next_floor;
   logic [FLOOR_W-1:0]      w_eval_floor;
   logic                    w_call_ok;
   logic                    w_call_here;
   logic [NUM_FLOORS-1:0]   w_eval_hot;
   logic [NUM_FLOORS-1:0]   w_above;
   logic [NUM_FLOORS-1:0]   w_below;
   logic [NUM_FLOORS-1:0]   w_call_hot;
   logic                    w_here;
   logic                    w_up_req;
   logic                    w_dn_req;
   logic                    w_ahead;
   logic                    w_behind;
   logic                    w_stop;
   logic [NUM_FLOORS-1:0]   w_set;
   logic [NUM_FLOORS-1:0]   w_clr;

   // Decisions are taken against the floor the car will occupy after this edge:
   // the stepped floor at the end of a travel segment, otherwise the current one.
   always_comb begin
      w_step       = ((r_state == S_MOVE_UP) || (r_state == S_MOVE_DN)) &&
                     (r_move_cnt == c_MOVE_LAST);
      w_next_floor = (r_state == S_MOVE_UP) ? (r_floor + FLOOR_W'(1))
                                            : (r_floor - FLOOR_W'(1));
      w_eval_floor = w_step ? w_next_floor : r_floor;
      w_call_ok    = call_valid && ({1'b0, call_floor} < c_FLOOR_LIMIT);
      w_call_here  = w_call_ok && (call_floor == r_floor);
      w_eval_hot   = '0;
      w_above      = '0;
      w_below      = '0;
      w_call_hot   = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         w_eval_hot[i] = (FLOOR_W'(i) == w_eval_floor);
         w_above[i]    = (FLOOR_W'(i) >  w_eval_floor);
         w_below[i]    = (FLOOR_W'(i) <  w_eval_floor);
         w_call_hot[i] = w_call_ok && (FLOOR_W'(i) == call_floor);
      end
      w_here   = |(r_pending & w_eval_hot);
      w_up_req = |(r_pending & w_above);
      w_dn_req = |(r_pending & w_below);
      w_ahead  = r_dir ? w_up_req : w_dn_req;
      w_behind = r_dir ? w_dn_req : w_up_req;
      // A stop clears its own bit even if a call for that floor lands the same edge.
      w_stop   = ((r_state == S_IDLE) || w_step) && w_here;
      w_clr    = w_stop ? w_eval_hot : '0;
      // A call for the floor whose door is already open only restarts the dwell.
      w_set    = ((r_state == S_DOOR_OPEN) && w_call_here) ? '0 : w_call_hot;
   end

   // Car FSM: call latching, SCAN direction choice, travel and door timers, alerts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_floor        <= c_RESET_FLOOR;
         r_dir          <= 1'b1;
         r_pending      <= '0;
         r_move_cnt     <= '0;
         r_door_cnt     <= '0;
         r_door_alert   <= 1'b0;
         r_weight_alert <= 1'b0;
      end else begin
         r_pending <= (r_pending | w_set) & ~w_clr;
         case (r_state)
            S_IDLE: begin
               r_move_cnt <= '0;
               if (w_here) begin
                  r_state    <= S_DOOR_OPEN;
                  r_door_cnt <= '0;
               end else if (w_ahead) begin
                  r_state <= r_dir ? S_MOVE_UP : S_MOVE_DN;
               end else if (w_behind) begin
                  r_dir   <= ~r_dir;
                  r_state <= r_dir ? S_MOVE_DN : S_MOVE_UP;
               end
            end
            S_MOVE_UP, S_MOVE_DN: begin
               if (!w_step) begin
                  r_move_cnt <= r_move_cnt + 1'b1;
               end else begin
                  r_floor    <= w_next_floor;
                  r_move_cnt <= '0;
                  if (w_here) begin
                     r_state    <= S_DOOR_OPEN;
                     r_door_cnt <= '0;
                  end else if (w_ahead) begin
                     r_state <= r_state;
                  end else if (w_behind) begin
                     r_dir   <= ~r_dir;
                     r_state <= (r_state == S_MOVE_UP) ? S_MOVE_DN : S_MOVE_UP;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_DOOR_OPEN: begin
               if (over_time || over_weight) begin
                  r_door_cnt     <= '0;
                  r_door_alert   <= over_time;
                  r_weight_alert <= over_weight;
               end else if (w_call_here) begin
                  r_door_cnt     <= '0;
                  r_door_alert   <= 1'b0;
                  r_weight_alert <= 1'b0;
               end else if (r_door_cnt == c_DOOR_LAST) begin
                  r_state        <= S_IDLE;
                  r_door_cnt     <= '0;
                  r_door_alert   <= 1'b0;
                  r_weight_alert <= 1'b0;
               end else begin
                  r_door_cnt     <= r_door_cnt + 1'b1;
                  r_door_alert   <= 1'b0;
                  r_weight_alert <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign current_floor = r_floor;
   assign direction     = r_dir;
   assign moving        = (r_state == S_MOVE_UP) || (r_state == S_MOVE_DN);
   assign door_open     = (r_state == S_DOOR_OPEN);
   assign complete      = (r_state == S_IDLE) && (r_pending == '0);
   assign door_alert    = r_door_alert;
   assign weight_alert  = r_weight_alert;
   assign pending       = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_pes_elc_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pes_elc_scan
//  Purpose  : Directed self-checking bench for pes_elc_scan: default 8-floor
//             car, a 16-floor single-cycle-travel car, and an 8-floor car
//             with a 4-bit floor index for out-of-range calls.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pes_elc_scan;

   logic       clk;
   logic       reset;
   logic       call_valid;
   logic [2:0] call_floor;
   logic       over_time;
   logic       over_weight;
   logic [2:0] current_floor;
   logic       direction, moving, door_open, complete, door_alert, weight_alert;
   logic [7:0] pending;

   logic        cv16;
   logic [3:0]  cf16;
   logic [3:0]  floor16;
   logic        dir16, mov16, door16, cmp16, da16, wa16;
   logic [15:0] pend16;

   logic        cv8w;
   logic [3:0]  cf8w;
   logic [3:0]  floor8w;
   logic        dir8w, mov8w, door8w, cmp8w, da8w, wa8w;
   logic [7:0]  pend8w;

   int n_checks = 0;
   int n_errors = 0;

   pes_elc_scan u_dut (
      .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
      .over_time(over_time), .over_weight(over_weight),
      .current_floor(current_floor), .direction(direction), .moving(moving),
      .door_open(door_open), .complete(complete), .door_alert(door_alert),
      .weight_alert(weight_alert), .pending(pending)
   );

   pes_elc_scan #(.NUM_FLOORS(16), .FLOOR_W(4), .MOVE_CYCLES(1)) u_dut16 (
      .clk(clk), .reset(reset), .call_valid(cv16), .call_floor(cf16),
      .over_time(1'b0), .over_weight(1'b0),
      .current_floor(floor16), .direction(dir16), .moving(mov16),
      .door_open(door16), .complete(cmp16), .door_alert(da16),
      .weight_alert(wa16), .pending(pend16)
   );

   pes_elc_scan #(.NUM_FLOORS(8), .FLOOR_W(4)) u_dut8w (
      .clk(clk), .reset(reset), .call_valid(cv8w), .call_floor(cf8w),
      .over_time(1'b0), .over_weight(1'b0),
      .current_floor(floor8w), .direction(dir8w), .moving(mov8w),
      .door_open(door8w), .complete(cmp8w), .door_alert(da8w),
      .weight_alert(wa8w), .pending(pend8w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_door(input logic want, input int limit, input string tag);
      int n = 0;
      while (door_open !== want && n < limit) begin
         step();
         n++;
      end
      check(tag, {31'd0, door_open}, {31'd0, want});
   endtask

   // Linear directed sequence.
   initial begin
      reset = 1'b1; call_valid = 1'b0; call_floor = '0;
      over_time = 1'b0; over_weight = 1'b0;
      cv16 = 1'b0; cf16 = '0; cv8w = 1'b0; cf8w = '0;
      step();
      check("rst_floor",    current_floor, 0);
      check("rst_dir",      direction, 1);
      check("rst_pending",  pending, 0);
      check("rst_moving",   moving, 0);
      check("rst_door",     door_open, 0);
      check("rst_complete", complete, 1);
      check("rst_alerts",   {door_alert, weight_alert}, 0);
      #2 reset = 1'b0;

      // Single call from floor 0 to floor 2: latency and dwell.
      step();
      call_valid = 1'b1; call_floor = 3'd2;
      step();                                   // edge t
      call_valid = 1'b0;
      check("t1_pending_t", pending, 8'h04);
      check("t1_moving_t",  moving, 0);
      step();                                   // t+1
      check("t1_moving_t1", moving, 1);
      repeat (4) step();                        // t+5
      check("t1_floor_t5",  current_floor, 1);
      repeat (4) step();                        // t+9
      check("t1_floor_t9",  current_floor, 2);
      check("t1_door_t9",   door_open, 1);
      check("t1_pend_t9",   pending, 0);
      repeat (5) step();                        // t+14
      check("t1_door_t14",  door_open, 1);
      step();                                   // t+15
      check("t1_door_t15",  door_open, 0);
      check("t1_cmpl_t15",  complete, 1);

      // SCAN: call 6 from floor 2, then call 1 while passing floor 3 going up.
      call_valid = 1'b1; call_floor = 3'd6;
      step();                                   // a
      call_valid = 1'b0;
      repeat (5) step();                        // a+5
      check("t2_floor3",    current_floor, 3);
      check("t2_moving",    moving, 1);
      call_valid = 1'b1; call_floor = 3'd1;
      step();                                   // a+6
      call_valid = 1'b0;
      check("t2_pending",   pending, 8'h42);
      wait_door(1'b1, 40, "t2_door6_open");
      check("t2_stop6",     current_floor, 6);
      check("t2_dir_up",    direction, 1);
      check("t2_pend6",     pending, 8'h02);
      wait_door(1'b0, 20, "t2_door6_close");
      step(); step();
      check("t2_dir_down",  direction, 0);
      check("t2_mov_down",  moving, 1);
      wait_door(1'b1, 60, "t2_door1_open");
      check("t2_stop1",     current_floor, 1);
      check("t2_pend1",     pending, 0);
      wait_door(1'b0, 20, "t2_door1_close");

      // Travel to floor 4, then hold the door with over_weight.
      call_valid = 1'b1; call_floor = 3'd4;
      step();
      call_valid = 1'b0;
      wait_door(1'b1, 40, "t3_door4_open");
      check("t3_floor4",    current_floor, 4);
      check("t3_dir_up",    direction, 1);
      step(); step();
      over_weight = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         check("t3_walert_hi", weight_alert, 1);
         check("t3_wdoor_hi",  door_open, 1);
      end
      over_weight = 1'b0;
      step();                                   // r1
      check("t3_walert_lo", weight_alert, 0);
      check("t3_wdoor_r1",  door_open, 1);
      repeat (4) step();                        // r5
      check("t3_wdoor_r5",  door_open, 1);
      step();                                   // r6
      check("t3_wdoor_r6",  door_open, 0);
      check("t3_wcmpl",     complete, 1);

      // Call at own floor while idle: door opens next edge with no travel.
      call_valid = 1'b1; call_floor = 3'd4;
      step();
      call_valid = 1'b0;
      check("t4_idle_pend", pending, 8'h10);
      check("t4_idle_door", door_open, 0);
      step();
      check("t4_here_door", door_open, 1);
      check("t4_here_mov",  moving, 0);
      check("t4_here_pend", pending, 0);
      check("t4_here_flr",  current_floor, 4);

      // Same dwell held with over_time.
      over_time = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         check("t3_dalert_hi", door_alert, 1);
         check("t3_dw_lo",     weight_alert, 0);
         check("t3_tdoor_hi",  door_open, 1);
      end
      over_time = 1'b0;
      step();
      check("t3_dalert_lo", door_alert, 0);
      repeat (4) step();
      check("t3_tdoor_r5",  door_open, 1);
      step();
      check("t3_tdoor_r6",  door_open, 0);

      // Call for current floor during DOOR_OPEN restarts the dwell timer.
      call_valid = 1'b1; call_floor = 3'd4;
      step();
      call_valid = 1'b0;
      step();                                   // o
      check("t4_rs_open",   door_open, 1);
      repeat (3) step();                        // o+3
      call_valid = 1'b1; call_floor = 3'd4;
      step();                                   // o+4
      call_valid = 1'b0;
      check("t4_rs_pend",   pending, 0);
      check("t4_rs_door",   door_open, 1);
      repeat (5) step();                        // o+9
      check("t4_rs_o9",     door_open, 1);
      step();                                   // o+10
      check("t4_rs_o10",    door_open, 0);

      // Asynchronous reset in the middle of a travel segment between 5 and 6.
      call_valid = 1'b1; call_floor = 3'd7;
      step();
      call_valid = 1'b0;
      repeat (7) step();
      check("t5_floor5",    current_floor, 5);
      check("t5_moving",    moving, 1);
      check("t5_pend",      pending, 8'h80);
      #2 reset = 1'b1;
      #1;
      check("t5_rst_floor", current_floor, 0);
      check("t5_rst_pend",  pending, 0);
      check("t5_rst_mov",   moving, 0);
      check("t5_rst_cmpl",  complete, 1);
      check("t5_rst_dir",   direction, 1);
      #2 reset = 1'b0;

      // 16-floor car, single-cycle travel: 0 -> 15.
      step();
      cv16 = 1'b1; cf16 = 4'd15;
      step();                                   // t
      cv16 = 1'b0;
      check("t6_pend",      pend16, 16'h8000);
      repeat (15) step();                       // t+15
      check("t6_floor14",   floor16, 14);
      check("t6_door_t15",  door16, 0);
      step();                                   // t+16
      check("t6_floor15",   floor16, 15);
      check("t6_door_t16",  door16, 1);
      check("t6_pend_clr",  pend16, 0);

      // Out-of-range call floors are ignored.
      cv8w = 1'b1; cf8w = 4'd8;
      step();
      check("t4_oor8_pend", pend8w, 0);
      check("t4_oor8_cmpl", cmp8w, 1);
      cf8w = 4'd15;
      step();
      check("t4_oor15_pend", pend8w, 0);
      cf8w = 4'd7;
      step();
      cv8w = 1'b0;
      check("t4_in7_pend",  pend8w, 8'h80);
      step();
      check("t4_in7_mov",   mov8w, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
